// File: rtl/gowin_iol_pkg.sv
// Shared types and defaults for the Gowin IO-logic reset/calibration sequencer.
// State encodings are fixed because other tooling decodes the 2-bit state.
package gowin_iol_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK  = 2'd0,
        ST_DIV_SETTLE = 2'd1,
        ST_READY      = 2'd2
    } seq_state_e;

    localparam int DEF_LOCK_WAIT     = 16;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_CALIB_GAP     = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with synchronous active-high clear, used for the
// asynchronous PLL lock input.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/gowin_iol_rst_seq.sv
// Releases the divided-clock generator after a stable PLL lock, then the
// IDES/OSER reset after a settle interval, and paces CALIB slip pulses.
module gowin_iol_rst_seq
    import gowin_iol_pkg::*;
#(
    parameter int LOCK_WAIT     = DEF_LOCK_WAIT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CALIB_GAP     = DEF_CALIB_GAP
) (
    input  logic clock,
    input  logic reset,
    input  logic pll_lock,
    input  logic calib_req,
    output logic clkdiv_resetn,
    output logic iologic_reset,
    output logic calib,
    output logic calib_busy,
    output logic ready
);

    localparam int CNT_MAX = max3(LOCK_WAIT, SETTLE_CYCLES, CALIB_GAP);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] ONE         = CW'(1);
    localparam logic [CW-1:0] CNT_SAT     = CW'(CNT_MAX);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_WAIT);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(CALIB_GAP);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_SAT) ? v : v + ONE;
    endfunction

    logic          lock_s;
    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] gcnt_q, gcnt_d;
    logic          busy_q, busy_d;
    logic          calib_q, calib_d;
    logic          clkdiv_q, iolrst_q, ready_q;
    logic          gap_free;

    sync2 u_lock_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    // A held request re-fires on the cycle the previous gap expires, so the
    // gap counter reaching its end counts as free even while busy is still set.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gcnt_d   = gcnt_q;
        busy_d   = busy_q;
        calib_d  = 1'b0;
        gap_free = !busy_q || (gcnt_q == GAP_LAST);

        unique case (state_q)
            ST_WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_DIV_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_DIV_SETTLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_READY: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    if (busy_q) begin
                        if (gcnt_q == GAP_LAST) begin
                            busy_d = 1'b0;
                        end else begin
                            gcnt_d = sat_inc(gcnt_q);
                        end
                    end
                    if (calib_req && gap_free) begin
                        calib_d = 1'b1;
                        busy_d  = 1'b1;
                        gcnt_d  = ONE;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        if (state_d != ST_READY) begin
            busy_d = 1'b0;
            gcnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so they move on the same edge
    // as the state itself; ready and the IO-logic release share one decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_WAIT_LOCK;
            cnt_q    <= '0;
            gcnt_q   <= '0;
            busy_q   <= 1'b0;
            calib_q  <= 1'b0;
            clkdiv_q <= 1'b0;
            iolrst_q <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
            busy_q   <= busy_d;
            calib_q  <= calib_d;
            clkdiv_q <= (state_d != ST_WAIT_LOCK);
            iolrst_q <= (state_d != ST_READY);
            ready_q  <= (state_d == ST_READY);
        end
    end

    assign clkdiv_resetn = clkdiv_q;
    assign iologic_reset = iolrst_q;
    assign calib         = calib_q;
    assign calib_busy    = busy_q;
    assign ready         = ready_q;

endmodule

// File: tb/tb_gowin_iol_rst_seq.sv
// Directed bench for gowin_iol_rst_seq with LOCK_WAIT=4, SETTLE_CYCLES=8,
// CALIB_GAP=4: a vector table for lock-up and calibration, then corner sequences.
module tb_gowin_iol_rst_seq;

    localparam int LW  = 4;
    localparam int SC  = 8;
    localparam int GAP = 4;
    localparam int NVEC = 38;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic pll_lock = 1'b0;
    logic calib_req = 1'b0;
    logic clkdiv_resetn;
    logic iologic_reset;
    logic calib;
    logic calib_busy;
    logic ready;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic lock;
        logic req;
        logic expDiv;
        logic expIolRst;
        logic expReady;
        logic expCalib;
        logic expBusy;
    } vec_t;

    vec_t vecs [NVEC];

    gowin_iol_rst_seq #(
        .LOCK_WAIT     (LW),
        .SETTLE_CYCLES (SC),
        .CALIB_GAP     (GAP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pll_lock      (pll_lock),
        .calib_req     (calib_req),
        .clkdiv_resetn (clkdiv_resetn),
        .iologic_reset (iologic_reset),
        .calib         (calib),
        .calib_busy    (calib_busy),
        .ready         (ready)
    );

    always #5 clock = ~clock;

    // Inputs set here are sampled by the next rising edge; outputs are then
    // observed 1 time unit after that edge.
    task automatic applyStimulus(input logic lock, input logic req, input logic rst);
        pll_lock  = lock;
        calib_req = req;
        reset     = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic d, input logic i,
                               input logic r, input logic c, input logic b);
        checkBit({tag, " clkdiv_resetn"}, clkdiv_resetn, d);
        checkBit({tag, " iologic_reset"}, iologic_reset, i);
        checkBit({tag, " ready"}, ready, r);
        checkBit({tag, " calib"}, calib, c);
        checkBit({tag, " calib_busy"}, calib_busy, b);
    endtask

    initial begin
        logic req;

        // Row i is sampled at edge i, where edge 0 is the first to see lock=1.
        // Divider release at 6, IO release at 14; calib held rows 20..31
        // pulses at 20/24/28, then a single request at 33 and a dropped one at 35.
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].lock      = 1'b1;
            vecs[i].req       = (i >= 20 && i <= 31) || i == 33 || i == 35;
            vecs[i].expDiv    = (i >= 6);
            vecs[i].expIolRst = (i < 14);
            vecs[i].expReady  = (i >= 14);
            vecs[i].expCalib  = (i == 20) || (i == 24) || (i == 28) || (i == 33);
            vecs[i].expBusy   = (i >= 20 && i <= 31) || (i >= 33 && i <= 36);
        end

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("noLock", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].lock, vecs[i].req, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].expDiv, vecs[i].expIolRst,
                        vecs[i].expReady, vecs[i].expCalib, vecs[i].expBusy);
        end

        // Lock loss during a calibration gap: pulse at edge k, lock low after it.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("lossPulse", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkBit("lossK2 ready", ready, 1'b1);
        checkBit("lossK2 calib_busy", calib_busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("lossK3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("lossHold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int e = 0; e <= 15; e++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("relock%0d", e), (e >= 6), (e < 14), (e >= 14),
                        1'b0, 1'b0);
        end

        // Synchronous reset in READY beats a simultaneous request.
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("syncReset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Requests during divider settle are dropped, not queued.
        for (int e = 0; e <= 21; e++) begin
            req = (e >= 7 && e <= 10) || (e == 21);
            applyStimulus(1'b1, req, 1'b0);
            checkOutput($sformatf("settleReq%0d", e), (e >= 6), (e < 14), (e >= 14),
                        (e == 21), (e == 21));
        end

        // One-cycle glitch at edge 3 restarts the lock count.
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
        for (int e = 0; e <= 11; e++) begin
            applyStimulus((e != 3), 1'b0, 1'b0);
            checkOutput($sformatf("glitch%0d", e), (e >= 10), 1'b1, 1'b0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
